// File: rtl/mod_reduce_if.sv
// ---------------------------------------------------------------------------
// mod_reduce_if
//   Operand/residue handshake bundle for mod_reduce_seq.
//   Parameters: WIDTH (operand bits), RW (residue bits).
//   Signals:
//     in_valid  - producer offers operand X
//     in_ready  - reducer can take X this cycle
//     X         - unsigned operand
//     out_valid - residue R is valid
//     out_ready - consumer takes R this cycle
//     R         - residue, < MOD whenever out_valid is high
//   master = producer/consumer side, slave = reducer side.
// ---------------------------------------------------------------------------
interface mod_reduce_if #(
  parameter int WIDTH = 200,
  parameter int RW    = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    R;

  modport master (
    output in_valid, X, out_ready,
    input  in_ready, out_valid, R
  );

  modport slave (
    input  in_valid, X, out_ready,
    output in_ready, out_valid, R
  );
endinterface

// File: rtl/mod_reduce_seq.sv
// ---------------------------------------------------------------------------
// mod_reduce_seq
//   Sequential residue engine: R = X mod MOD, folding CHUNK operand bits per
//   clock, most significant chunk first (Horner form). One small fold
//   datapath reused NCHUNK times.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     io   - mod_reduce_if slave (in_valid/in_ready/X, out_valid/out_ready/R)
//     busy - high while a fold is in progress
//   Parameters: WIDTH (>=1), MOD (2..65535), CHUNK (1..8).
// ---------------------------------------------------------------------------
module mod_reduce_seq #(
  parameter int WIDTH = 200,
  parameter int MOD   = 241,
  parameter int CHUNK = 6
) (
  input  logic          clk,
  input  logic          rst,
  mod_reduce_if.slave   io,
  output logic          busy
);

  localparam int RW     = $clog2(MOD);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int SW     = NCHUNK * CHUNK;           // padded shift width
  localparam int TW     = RW + CHUNK;               // fold intermediate width
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_ready;
  logic            accept;
  logic [TW-1:0]   fold_t;

  // One Horner step: (acc*2^CHUNK + top chunk) mod MOD. Since acc < MOD the
  // intermediate is below MOD*2^CHUNK, so a restoring chain that tries the
  // shifted modulus for k = CHUNK-1..0 leaves an exact residue.
  // NOTE: fold_t is a combinational scratch variable updated step by step,
  // so the chain uses blocking '='; each step must see the previous result.
  always_comb begin
    fold_t = {acc_q, sr_q[SW-1 -: CHUNK]};
    for (int k = CHUNK - 1; k >= 0; k--) begin
      if (fold_t >= (TW'(MOD) << k)) begin
        fold_t = fold_t - (TW'(MOD) << k);
      end
    end
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && io.out_ready);
  assign accept   = io.in_valid && in_ready;

  // NOTE: every variable gets its hold value first so that branches which do
  // not assign it cannot infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: ;
      S_RUN: begin
        acc_d = fold_t[RW-1:0];
        sr_d  = sr_q << CHUNK;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load overrides the above in IDLE and in a consuming DONE cycle, which
    // is what gives back-to-back operation with no idle gap.
    if (accept) begin
      sr_d    = SW'(io.X);   // zero-extended at the MSB end
      acc_d   = '0;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // R comes straight from the accumulator flops; no path from X to R.
  assign io.R         = acc_q;
  assign io.out_valid = (state_q == S_DONE);
  assign io.in_ready  = in_ready;
  assign busy         = (state_q == S_RUN);

endmodule

// File: tb/tb_mod_reduce_seq.sv
// ---------------------------------------------------------------------------
// tb_mod_reduce_seq
//   Scoreboard bench for mod_reduce_seq. Drivers push the expected residue
//   when an operand is accepted; per-instance monitors pop and compare on
//   every out_valid && out_ready handshake.
//   u0: defaults (200 bits, mod 241, chunk 6), directed hand-computed vectors.
//   u1: WIDTH=13 MOD=7 CHUNK=4, u2: WIDTH=64 MOD=251 CHUNK=1, random
//   operands with random out_ready stalls, expected from X % MOD.
// ---------------------------------------------------------------------------
module tb_mod_reduce_seq;

  logic clk = 1'b0;
  logic rst;
  logic busy0, busy1, busy2;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic sweep_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_reduce_if #(.WIDTH(200), .RW(8)) i0 ();
  mod_reduce_if #(.WIDTH(13),  .RW(3)) i1 ();
  mod_reduce_if #(.WIDTH(64),  .RW(8)) i2 ();

  mod_reduce_seq #(.WIDTH(200), .MOD(241), .CHUNK(6)) u0 (
    .clk(clk), .rst(rst), .io(i0.slave), .busy(busy0));
  mod_reduce_seq #(.WIDTH(13), .MOD(7), .CHUNK(4)) u1 (
    .clk(clk), .rst(rst), .io(i1.slave), .busy(busy1));
  mod_reduce_seq #(.WIDTH(64), .MOD(251), .CHUNK(1)) u2 (
    .clk(clk), .rst(rst), .io(i2.slave), .busy(busy2));

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int out_cyc_prev = 0;
  int out_cyc_last = 0;
  int acc_cyc = 0;

  localparam logic [199:0] ALL1 = '1;
  localparam logic [199:0] P199 = 200'(1) << 199;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && i0.out_valid && i0.out_ready) begin
      check("u0_out_expected", 64'(q0.size() != 0), 1);
      if (q0.size() != 0) check("u0_R", 64'(i0.R), 64'(q0.pop_front()));
      check("u0_R_lt_mod", 64'(i0.R < 241), 1);
      out_cyc_prev = out_cyc_last;
      out_cyc_last = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && i1.out_valid && i1.out_ready) begin
      check("u1_out_expected", 64'(q1.size() != 0), 1);
      if (q1.size() != 0) check("u1_R", 64'(i1.R), 64'(q1.pop_front()));
      check("u1_R_lt_mod", 64'(i1.R < 7), 1);
    end
  end

  always @(negedge clk) begin
    if (!rst && i2.out_valid && i2.out_ready) begin
      check("u2_out_expected", 64'(q2.size() != 0), 1);
      if (q2.size() != 0) check("u2_R", 64'(i2.R), 64'(q2.pop_front()));
      check("u2_R_lt_mod", 64'(i2.R < 251), 1);
    end
  end

  // Random consumer stalls for the sweep instances.
  always @(posedge clk) begin
    #1;
    i1.out_ready = sweep_on && ($urandom_range(0, 3) != 0);
    i2.out_ready = sweep_on && ($urandom_range(0, 3) != 0);
  end

  // ---------------- drivers (called at posedge + #1) ----------------
  task automatic send0(input logic [199:0] x, input logic [7:0] exp, input bit push);
    int n = 0;
    i0.in_valid = 1'b1;
    i0.X        = x;
    @(negedge clk);
    while (!i0.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("u0_accept", 64'(i0.in_ready), 1);
    if (push) q0.push_back(16'(exp));
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    i0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [12:0] x);
    int n = 0;
    i1.in_valid = 1'b1;
    i1.X        = x;
    @(negedge clk);
    while (!i1.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("u1_accept", 64'(i1.in_ready), 1);
    q1.push_back(16'(x % 13'd7));
    @(posedge clk);
    #1;
    i1.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [63:0] x);
    int n = 0;
    i2.in_valid = 1'b1;
    i2.X        = x;
    @(negedge clk);
    while (!i2.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("u2_accept", 64'(i2.in_ready), 1);
    q2.push_back(16'(x % 64'd251));
    @(posedge clk);
    #1;
    i2.in_valid = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("u0_drain", 64'(q0.size()), 0);
  endtask

  task automatic wait_valid0();
    int n = 0;
    @(negedge clk);
    while (!i0.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("u0_out_valid_seen", 64'(i0.out_valid), 1);
  endtask

  // Global watchdog.
  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int bcnt;
    rst = 1'b1;
    i0.in_valid = 1'b0; i0.X = '0; i0.out_ready = 1'b1;
    i1.in_valid = 1'b0; i1.X = '0;
    i2.in_valid = 1'b0; i2.X = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready",  64'(i0.in_ready), 1);
    check("rst_out_valid", 64'(i0.out_valid), 0);
    check("rst_R",         64'(i0.R), 0);
    check("rst_busy",      64'(busy0), 0);
    @(posedge clk); #1;

    // X=0: latency and busy length.
    send0('0, 8'd0, 1'b1);
    n = 0; bcnt = 0;
    @(negedge clk);
    while (!i0.out_valid && n < 100) begin
      if (busy0) bcnt++;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(cyc - acc_cyc), 34);
    check("busy_cycles", 64'(bcnt), 34);
    drain0();
    @(posedge clk); #1;

    // Directed operands.
    send0(200'd240, 8'd240, 1'b1);
    send0(200'd241, 8'd0,   1'b1);
    send0(P199,     8'd128, 1'b1);
    drain0();
    @(posedge clk); #1;

    // All-ones with consumer stalled for 10 cycles.
    i0.out_ready = 1'b0;
    send0(ALL1, 8'd14, 1'b1);
    wait_valid0();
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", 64'(i0.out_valid), 1);
      check("hold_R",         64'(i0.R), 14);
      check("hold_in_ready",  64'(i0.in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    i0.out_ready = 1'b1;
    drain0();
    @(posedge clk); #1;

    // Back-to-back with out_ready held high.
    send0(ALL1,     8'd14, 1'b1);
    send0(200'd241, 8'd0,  1'b1);
    drain0();
    check("b2b_spacing", 64'(out_cyc_last - out_cyc_prev), 35);
    @(posedge clk); #1;

    // Reset in the middle of a fold; the abandoned operand must not emerge.
    send0(ALL1, 8'd14, 1'b0);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready",  64'(i0.in_ready), 1);
    check("midrst_out_valid", 64'(i0.out_valid), 0);
    check("midrst_R",         64'(i0.R), 0);
    check("midrst_busy",      64'(busy0), 0);
    @(posedge clk); #1;
    send0(200'd500, 8'd18, 1'b1);
    drain0();

    // Parameter sweeps, both instances in parallel.
    @(posedge clk); #1;
    sweep_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) send1(13'($urandom()));
      end
      begin
        for (int i = 0; i < 1000; i++) send2({$urandom(), $urandom()});
      end
    join
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("u1_drain", 64'(q1.size()), 0);
    check("u2_drain", 64'(q2.size()), 0);
    check("u0_idle_after_sweep", 64'(q0.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_reduce_seq.md
# mod_reduce_seq

Sequential, parametrised residue engine: computes R = X mod MOD for a WIDTH-bit operand by folding CHUNK bits per clock (MSB chunk first, Horner form), using a valid/ready handshake on both sides. It is the area-lean successor to the fixed 200-bit / mod-241 combinational reducer. It trades latency for a single small fold datapath. It sits between operand staging registers and the residue-number-system channel logic, one instance per modulus channel.

## Interface
- WIDTH, 200: operand width in bits, ≥ 1.
- MOD, 241: modulus, 2 ≤ MOD < 2^16.
- CHUNK, 6: bits folded per cycle, 1..8.
- RW, clog2(MOD): residue width (derived; 8 for 241).
- NCHUNK, ceil(WIDTH/CHUNK): fold cycles (derived; 34 for defaults).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  X is valid.
- in_ready  out  1  block can accept X this cycle.
- X  in  WIDTH  operand, unsigned.
- out_valid  out  1  R is valid.
- out_ready  in  1  consumer accepts R this cycle.
- R  out  RW  residue, always < MOD when out_valid.
- busy  out  1  high in RUN.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: fold in progress.
  - DONE: out_valid=1, R held stable.
- Input acceptance:
  - Accept on an edge with in_valid && in_ready.
  - Capture X into a shift register, zero-padded at the MSB end to NCHUNK*CHUNK bits.
  - Clear the accumulator acc to 0 and the chunk counter to 0, then go to RUN.
- RUN, each cycle:
  - c = top CHUNK bits of the shift register.
  - acc ← (acc·2^CHUNK + c) mod MOD.
  - Shift the register left by CHUNK bits; increment the counter.
  - After the fold with counter = NCHUNK−1, go to DONE.
- Fold arithmetic:
  - acc < MOD is invariant, so the intermediate is < MOD·2^CHUNK and needs RW+CHUNK bits.
  - Reduce with a restoring chain: for k = CHUNK−1 down to 0, subtract MOD·2^k if the intermediate ≥ MOD·2^k.
  - The result must be exact; no lazy or partial reduction is allowed.
- DONE:
  - R = acc.
  - On out_ready, the result is consumed and the block goes to IDLE.
  - If in_valid is also high on that edge, accept the new operand and go directly to RUN (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is combinational from state and out_ready; it has no combinational path from in_valid.
- In RUN, in_valid is ignored and X is not sampled.
- In DONE, R and out_valid are held while out_ready=0, indefinitely.

## Timing
- Reset values: state IDLE, out_valid=0, R=0, busy=0, in_ready=1 (combinational from IDLE), accumulator/shift register/counter = 0.
- Reset mid-RUN or in DONE: the operation is abandoned, the result is discarded, and nothing is emitted afterwards.
- Latency:
  - Acceptance at edge T; out_valid first high in the cycle after edge T+NCHUNK.
  - With defaults that is 34 clock cycles after the accepting edge.
- Throughput:
  - One operand per NCHUNK+1 cycles when out_ready is held high (DONE lasts one cycle, with the back-to-back accept in it).
  - With out_ready held low, throughput is bounded by the consumer.
- R is registered; there is no combinational path from X to R.
- WIDTH not a multiple of CHUNK: the zero padding occupies the first folded chunk and does not change the result.

## Test plan
- Reset, then in_valid with X=0 → out_valid rises 34 cycles after acceptance, R=0, busy high for exactly 34 cycles.
- Three operands:
  - X=240 → R=240.
  - X=241 → R=0.
  - X=2^199 → R=128.
  - Each is checked against a reference model.
- X=2^200−1 → R=14. Hold out_ready=0 for 10 cycles: R and out_valid remain stable, in_ready=0 throughout.
- Back-to-back: out_ready=1 and in_valid=1 continuously with X=2^200−1 then X=241 → results 14 then 0, second out_valid exactly 35 cycles after the first, no idle cycle.
- Assert rst at fold cycle 17 of an operand → next cycle in IDLE, out_valid=0, R=0. A fresh X=500 then yields R=18.
- Parameter sweep (WIDTH=13, MOD=7, CHUNK=4; WIDTH=64, MOD=251, CHUNK=1), 1000 random operands each with random out_ready stalls → all R match X mod MOD, every R < MOD.
